// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: registered control word behind valid/ready, load-use scoreboard, flush.
// Define DECODE_ILLEGAL_INSN_EN to add the registered out_illegal flag.
module decode_stage #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_insn,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [2:0]        out_alu_op,
  output logic [1:0]        out_alu_src,
  output logic [1:0]        out_branch_sel,
  output logic [2:0]        out_brcmp_src,
  output logic              out_mr_sel,
  output logic              out_mtr_sel,
  output logic              out_mw_sel,
  output logic              out_rw_sel,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd
`ifdef DECODE_ILLEGAL_INSN_EN
  ,
  output logic              out_illegal
`endif
);

  typedef enum logic [6:0] {
    OPC_LOAD = 7'h03, OPC_OPIMM = 7'h13, OPC_AUIPC = 7'h17, OPC_STORE = 7'h23,
    OPC_OP = 7'h33, OPC_LUI = 7'h37, OPC_BRANCH = 7'h63, OPC_JALR = 7'h67, OPC_JAL = 7'h6F
  } opcode_e;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [1:0] {SRC_RF, SRC_SE, SRC_ZE} alu_src_e;
  typedef enum logic [1:0] {BR_SEQ, BR_BRANCH, BR_JAL, BR_JALR} br_sel_e;
  typedef enum logic [2:0] {
    CMP_BEQ, CMP_BNE, CMP_BLT, CMP_BGE, CMP_BLTU, CMP_BGEU, CMP_NONE = 3'd7
  } brcmp_e;

  // alt is insn[30]; for register ops any alt combination not listed falls back to add.
  function automatic alu_op_e f_alu(input logic [2:0] f3, input logic alt, input logic is_imm);
    logic a;
    a = alt && !is_imm;
    case (f3)
      3'b000:  f_alu = a   ? ALU_SUB : ALU_ADD;
      3'b001:  f_alu = alt ? ALU_ADD : ALU_SLL;
      3'b100:  f_alu = a   ? ALU_ADD : ALU_XOR;
      3'b101:  f_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f_alu = a   ? ALU_ADD : ALU_OR;
      3'b111:  f_alu = a   ? ALU_ADD : ALU_AND;
      default: f_alu = ALU_ADD;
    endcase
  endfunction

  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_imm;
  alu_op_e           w_alu_op;
  alu_src_e          w_alu_src;
  br_sel_e           w_br_sel;
  brcmp_e            w_brcmp;
  logic              w_mr, w_mtr, w_mw, w_rw, w_use_rs1, w_use_rs2;
  logic              w_hazard, w_accept, w_sb_ok;
  logic [NUM_REGS-1:0] w_busy_nxt;

  logic                r_valid, r_sb;
  logic [NUM_REGS-1:0] r_busy;
  logic [REG_AW-1:0]   r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0]     r_imm, r_pc;
  alu_op_e             r_alu_op;
  alu_src_e            r_alu_src;
  br_sel_e             r_br_sel;
  brcmp_e              r_brcmp;
  logic                r_mr, r_mtr, r_mw, r_rw;

  assign w_f3    = in_insn[14:12];
  assign w_f7    = in_insn[31:25];
  assign w_rs1   = REG_AW'(in_insn[19:15]);
  assign w_rs2   = REG_AW'(in_insn[24:20]);
  assign w_rd    = REG_AW'(in_insn[11:7]);
  assign w_imm_i = XLEN'($signed(in_insn[31:20]));
  assign w_imm_s = XLEN'($signed({in_insn[31:25], in_insn[11:7]}));
  assign w_imm_b = XLEN'($signed({in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0}));
  assign w_imm_u = XLEN'($signed({in_insn[31:12], 12'h000}));

  always_comb begin
    w_alu_op  = ALU_ADD;
    w_alu_src = SRC_RF;
    w_br_sel  = BR_SEQ;
    w_brcmp   = CMP_NONE;
    w_mr      = 1'b0;
    w_mtr     = 1'b0;
    w_mw      = 1'b0;
    w_rw      = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_imm     = '0;
    case (in_insn[6:0])
      OPC_OP: begin
        w_alu_op  = (w_f7 == 7'h00 || w_f7 == 7'h20) ? f_alu(w_f3, in_insn[30], 1'b0) : ALU_ADD;
        w_rw      = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        w_alu_op  = f_alu(w_f3, in_insn[30], 1'b1);
        w_alu_src = SRC_SE;
        w_rw      = 1'b1;
        w_use_rs1 = 1'b1;
        w_imm     = w_imm_i;
      end
      OPC_LOAD: begin
        w_alu_src = SRC_ZE;
        w_mr      = 1'b1;
        w_mtr     = 1'b1;
        w_rw      = 1'b1;
        w_use_rs1 = 1'b1;
        w_imm     = w_imm_i;
      end
      OPC_STORE: begin
        w_alu_src = SRC_ZE;
        w_mw      = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_s;
      end
      OPC_BRANCH: begin
        w_alu_op  = ALU_SUB;
        w_br_sel  = BR_BRANCH;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_b;
        case (w_f3)
          3'b000:  w_brcmp = CMP_BEQ;
          3'b001:  w_brcmp = CMP_BNE;
          3'b100:  w_brcmp = CMP_BLT;
          3'b101:  w_brcmp = CMP_BGE;
          3'b110:  w_brcmp = CMP_BLTU;
          3'b111:  w_brcmp = CMP_BGEU;
          default: w_brcmp = CMP_NONE;
        endcase
      end
      OPC_JAL: begin
        w_br_sel = BR_JAL;
        w_rw     = 1'b1;
        w_imm    = w_imm_j;
      end
      OPC_JALR: begin
        w_br_sel  = BR_JALR;
        w_rw      = 1'b1;
        w_use_rs1 = 1'b1;
        w_imm     = w_imm_i;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_alu_src = SRC_ZE;
        w_rw      = 1'b1;
        w_imm     = w_imm_u;
      end
      default: ;
    endcase
  end

`ifdef DECODE_ILLEGAL_INSN_EN
  logic w_illegal, r_illegal;

  always_comb begin
    w_illegal = (in_insn[1:0] != 2'b11);
    case (in_insn[6:0])
      OPC_OP:     if (!(w_f7 == 7'h00 || w_f7 == 7'h20)) w_illegal = 1'b1;
      OPC_BRANCH: if (w_f3[2:1] == 2'b01) w_illegal = 1'b1;
      OPC_LOAD:   if (XLEN == 64 ? (w_f3 == 3'b111) : !(w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                    w_illegal = 1'b1;
      OPC_STORE:  if (w_f3[2] || (XLEN != 64 && w_f3 == 3'b011)) w_illegal = 1'b1;
      OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: ;
      default:    w_illegal = 1'b1;
    endcase
  end

  assign w_sb_ok     = !w_illegal;
  assign out_illegal = r_illegal;

  always_ff @(posedge clk) begin
    if (rst)           r_illegal <= 1'b0;
    else if (w_accept) r_illegal <= w_illegal;
  end
`else
  assign w_sb_ok = 1'b1;
`endif

  assign w_hazard = in_valid && ((w_use_rs1 && r_busy[w_rs1]) || (w_use_rs2 && r_busy[w_rs2]));
  assign in_ready = !flush && !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Set beats clear; a flushed load that never reached execute gives back its busy bit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_rd] = 1'b0;
    if (flush && r_valid && !out_ready && r_sb) w_busy_nxt[r_rd] = 1'b0;
    if (w_accept && w_mr && w_sb_ok && (w_rd != '0)) w_busy_nxt[w_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_sb      <= 1'b0;
      r_busy    <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_alu_op  <= ALU_ADD;
      r_alu_src <= SRC_RF;
      r_br_sel  <= BR_SEQ;
      r_brcmp   <= CMP_NONE;
      r_mr      <= 1'b0;
      r_mtr     <= 1'b0;
      r_mw      <= 1'b0;
      r_rw      <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid   <= 1'b1;
        r_sb      <= w_mr && w_sb_ok && (w_rd != '0);
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_rd      <= w_rd;
        r_imm     <= w_imm;
        r_pc      <= in_pc;
        r_alu_op  <= w_alu_op;
        r_alu_src <= w_alu_src;
        r_br_sel  <= w_br_sel;
        r_brcmp   <= w_brcmp;
        r_mr      <= w_mr;
        r_mtr     <= w_mtr;
        r_mw      <= w_mw;
        r_rw      <= w_rw;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_rs1        = r_rs1;
  assign out_rs2        = r_rs2;
  assign out_rd         = r_rd;
  assign out_imm        = r_imm;
  assign out_pc         = r_pc;
  assign out_alu_op     = r_alu_op;
  assign out_alu_src    = r_alu_src;
  assign out_branch_sel = r_br_sel;
  assign out_brcmp_src  = r_brcmp;
  assign out_mr_sel     = r_mr;
  assign out_mtr_sel    = r_mtr;
  assign out_mw_sel     = r_mw;
  assign out_rw_sel     = r_rw;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: XLEN=32 instance plus an XLEN=64 instance on the same stimulus.
module tb_decode_stage;

  logic        clk, rst, in_valid, out_ready, flush, wb_valid;
  logic [31:0] in_insn, in_pc;
  logic [63:0] in_pc64;
  logic [4:0]  wb_rd;

  logic        in_ready, out_valid, mr, mtr, mw, rw;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, pc;
  logic [2:0]  alu_op, brcmp;
  logic [1:0]  alu_src, bsel;

  logic        d_in_ready, d_out_valid, d_mr, d_mtr, d_mw, d_rw;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [63:0] d_imm, d_pc;
  logic [2:0]  d_alu_op, d_brcmp;
  logic [1:0]  d_alu_src, d_bsel;
`ifdef DECODE_ILLEGAL_INSN_EN
  logic        illegal, d_illegal;
`endif

  int total = 0;
  int bad   = 0;

  assign in_pc64 = {32'h0, in_pc};

  decode_stage #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_rs1(rs1), .out_rs2(rs2),
    .out_rd(rd), .out_imm(imm), .out_pc(pc), .out_alu_op(alu_op), .out_alu_src(alu_src),
    .out_branch_sel(bsel), .out_brcmp_src(brcmp), .out_mr_sel(mr), .out_mtr_sel(mtr),
    .out_mw_sel(mw), .out_rw_sel(rw), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd)
`ifdef DECODE_ILLEGAL_INSN_EN
    , .out_illegal(illegal)
`endif
  );

  decode_stage #(.XLEN(64), .NUM_REGS(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_insn(in_insn),
    .in_pc(in_pc64), .out_valid(d_out_valid), .out_ready(out_ready), .out_rs1(d_rs1),
    .out_rs2(d_rs2), .out_rd(d_rd), .out_imm(d_imm), .out_pc(d_pc), .out_alu_op(d_alu_op),
    .out_alu_src(d_alu_src), .out_branch_sel(d_bsel), .out_brcmp_src(d_brcmp),
    .out_mr_sel(d_mr), .out_mtr_sel(d_mtr), .out_mw_sel(d_mw), .out_rw_sel(d_rw),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd)
`ifdef DECODE_ILLEGAL_INSN_EN
    , .out_illegal(d_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] insn);
    in_valid = 1'b1;
    in_insn  = insn;
    in_pc    = in_pc + 32'd4;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc = 32'h100;
    out_ready = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_brcmp", brcmp, 3'd7);
    chk("rst_imm", imm, 0);
    chk("rst_rw", rw, 0);
    chk("rst_alu_src", alu_src, 0);
    rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);

    // addi x5,x1,-3
    send(32'hFFD08293);
    #1 chk("addi_in_ready", in_ready, 1);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", rd, 5);
    chk("addi_rs1", rs1, 1);
    chk("addi_imm", imm, 32'hFFFFFFFD);
    chk("addi_imm64", d_imm, 64'hFFFFFFFFFFFFFFFD);
    chk("addi_alu_src", alu_src, 1);
    chk("addi_rw", rw, 1);
    chk("addi_brcmp", brcmp, 3'd7);
    chk("addi_pc", pc, 32'h104);
`ifdef DECODE_ILLEGAL_INSN_EN
    chk("addi_illegal", illegal, 0);
`endif
    in_valid = 1'b0;
    tick();
    chk("handoff_valid", out_valid, 0);

    // lw x6,0(x2) then add x7,x6,x1 stalls until writeback of x6
    send(32'h00012303);
    tick();
    chk("lw_valid", out_valid, 1);
    chk("lw_mr", mr, 1);
    chk("lw_mtr", mtr, 1);
    chk("lw_alu_src", alu_src, 2);
    chk("lw_rd", rd, 6);
    send(32'h001303B3);
    #1 chk("use_stall0", in_ready, 0);
    tick();
    chk("stall_valid", out_valid, 0);
    chk("use_stall1", in_ready, 0);
    wb_valid = 1'b1; wb_rd = 5'd6;
    #1 chk("use_stall_wb", in_ready, 0);
    tick();
    wb_valid = 1'b0;
    #1 chk("use_release", in_ready, 1);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_rd", rd, 7);
    chk("add_rs1", rs1, 6);
    chk("add_rs2", rs2, 1);
    chk("add_alu_src", alu_src, 0);
    chk("add_mr", mr, 0);

    // lw x0 never marks a register busy
    send(32'h00012003);
    tick();
    chk("lw0_rd", rd, 0);
    send(32'h000003B3);
    #1 chk("lw0_no_stall", in_ready, 1);
    tick();
    chk("add0_rd", rd, 7);
    in_valid = 1'b0;
    tick();

    // beq x1,x2,-8 held under backpressure; srai pending behind it
    out_ready = 1'b0;
    send(32'hFE208CE3);
    tick();
    send(32'h4030D213);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_imm", imm, 32'hFFFFFFF8);
      chk("bp_brcmp", brcmp, 0);
      chk("bp_bsel", bsel, 1);
      chk("bp_alu_op", alu_op, 1);
      chk("bp_rs2", rs2, 2);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 1);
    tick();
    chk("srai_rd", rd, 4);
    chk("srai_alu_op", alu_op, 5);
    chk("srai_alu_src", alu_src, 1);
    chk("srai_imm", imm, 32'h403);

    // back-to-back: sub, sw, jal, unknown opcode
    send(32'h402081B3);
    tick();
    chk("sub_alu_op", alu_op, 1);
    chk("sub_rd", rd, 3);
    send(32'h00512623);
    tick();
    chk("sw_mw", mw, 1);
    chk("sw_rw", rw, 0);
    chk("sw_imm", imm, 12);
    chk("sw_alu_src", alu_src, 2);
    send(32'h008000EF);
    tick();
    chk("jal_bsel", bsel, 2);
    chk("jal_rw", rw, 1);
    chk("jal_imm", imm, 8);
    chk("jal_brcmp", brcmp, 3'd7);
    send(32'h0000000B);
    tick();
    chk("unk_valid", out_valid, 1);
    chk("unk_rw", rw, 0);
    chk("unk_bsel", bsel, 0);
    chk("unk_brcmp", brcmp, 3'd7);
    in_valid = 1'b0;
    tick();

    // flush an unhanded lw x9; add x1,x9,x9 must then go without a stall
    out_ready = 1'b0;
    send(32'h00012483);
    tick();
    chk("lw9_valid", out_valid, 1);
    send(32'h009480B3);
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    #1 chk("flush_busy_cleared", in_ready, 1);
    tick();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_rs1", rs1, 9);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // lui x3,0x80000 on both widths
    send(32'h800001B7);
    tick();
    chk("lui_imm32", imm, 32'h80000000);
    chk("lui_valid64", d_out_valid, 1);
    chk("lui_imm64", d_imm, 64'hFFFFFFFF80000000);
    chk("lui_alu_src", alu_src, 2);
    in_valid = 1'b0;
    tick();

    // reset during backpressure with a held lw x10
    out_ready = 1'b0;
    send(32'h00012503);
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_brcmp", brcmp, 3'd7);
    chk("mid_rst_rd", rd, 0);
    send(32'h00A500B3);
    #1 chk("mid_rst_busy_cleared", in_ready, 1);
    tick();
    chk("mid_rst_accept", out_valid, 1);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

`ifdef DECODE_ILLEGAL_INSN_EN
    send(32'h00000000);
    tick();
    chk("zero_illegal", illegal, 1);
    chk("zero_rw", rw, 0);
    in_valid = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
